// File: rtl/bsg_pkg.sv
// bsg_pkg: shared types and constants for the BSG serial transmit engine.
// Optional feature macro used by the engine: BSG_TX_PARITY_EN.
package bsg_pkg;

    // Number of payload bits in one serial frame (data1 then data2).
    localparam int FRAME_BITS = 16;

    // Bit positions inside the 5-bit status word returned to BSG_CONTROL[7:3].
    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_ERR  = 2;

    // Frame phase; the encoding is what appears on status[4:3].
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_e;

    // Even parity of a full frame word.
    function automatic logic even_parity(input logic [FRAME_BITS-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/bsg_tx_serializer_if.sv
// bsg_tx_serializer_if: register-block side bundle of the serial transmit engine.
interface bsg_tx_serializer_if;

    // tx_enable is a level, not a valid/ready pair: the engine starts one
    // frame per low-to-high transition seen in IDLE, keeps sending while it
    // stays high, and aborts the frame if it is seen low mid-frame.  data1 and
    // data2 only need to be stable on the cycle the frame starts.  There is no
    // back-pressure; the register block watches status (BUSY/DONE/ERR).
    logic       tx_enable;
    logic [7:0] data1;
    logic [7:0] data2;
    logic [4:0] status;
    logic       tx_data;
    logic       tx_clk;
    logic       tx_frame;

    // Register block side.
    modport master (
        output tx_enable, data1, data2,
        input  status, tx_data, tx_clk, tx_frame
    );

    // Serializer side.
    modport slave (
        input  tx_enable, data1, data2,
        output status, tx_data, tx_clk, tx_frame
    );

endinterface

// File: rtl/bsg_baud_cnt.sv
// bsg_baud_cnt: bit-period counter; bit_tick marks the last cycle of a bit time.
module bsg_baud_cnt #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic bit_tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: restart forces the first cycle of a bit, otherwise wrap at LAST.
    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_tick = (cnt_q == LAST);

endmodule

// File: rtl/bsg_tx_serializer.sv
// bsg_tx_serializer: shifts {data1,data2} out MSB first as a 16-bit serial frame,
// followed by an optional even-parity bit (macro BSG_TX_PARITY_EN) and a stop bit.
// CLK_DIV (2..256) sets the number of clk cycles per serial bit.
module bsg_tx_serializer
    import bsg_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bsg_tx_serializer_if.slave   bus
);

    localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

    state_e                  state_q, state_d;
    logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
    logic [3:0]              bit_cnt_q, bit_cnt_d;
    logic                    en_q, en_d;
    logic                    en_d1_q, en_d1_d;
    logic                    tx_data_q, tx_data_d;
    logic                    tx_clk_q, tx_clk_d;
    logic                    tx_frame_q, tx_frame_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    logic                    restart;
    logic                    bit_tick;
    logic                    rise;

    bsg_baud_cnt #(.CLK_DIV(CLK_DIV)) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .restart  (restart),
        .bit_tick (bit_tick)
    );

    // Start is a rise of the registered enable, so the input never reaches
    // an output combinationally.
    assign rise = en_q & ~en_d1_q;

    // Frame sequencing and next values of every registered output.  The shift
    // register rotates rather than shifts so that after the last data bit it
    // still holds the full frame word for the parity computation.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        en_d       = bus.tx_enable;
        en_d1_d    = en_q;
        tx_data_d  = tx_data_q;
        tx_clk_d   = 1'b0;
        tx_frame_d = tx_frame_q;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q;
        restart    = 1'b0;

        if (state_q == IDLE) begin
            if (rise) begin
                state_d    = SHIFT;
                shreg_d    = {bus.data1, bus.data2};
                bit_cnt_d  = '0;
                tx_data_d  = bus.data1[7];
                tx_clk_d   = 1'b1;
                tx_frame_d = 1'b1;
                busy_d     = 1'b1;
                done_d     = 1'b0;
                err_d      = 1'b0;
                restart    = 1'b1;
            end
        end else if (!en_q) begin
            // Enable withdrawn mid-frame: drop the frame, flag ERR, keep DONE.
            state_d    = IDLE;
            tx_data_d  = 1'b1;
            tx_frame_d = 1'b0;
            busy_d     = 1'b0;
            err_d      = 1'b1;
        end else if (bit_tick) begin
            tx_clk_d = 1'b1;
            case (state_q)
                SHIFT: begin
                    shreg_d = {shreg_q[FRAME_BITS-2:0], shreg_q[FRAME_BITS-1]};
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef BSG_TX_PARITY_EN
                        state_d   = PARITY;
                        tx_data_d = even_parity(shreg_q);
`else
                        state_d   = STOP;
                        tx_data_d = 1'b1;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        tx_data_d = shreg_q[FRAME_BITS-2];
                    end
                end
                PARITY: begin
                    state_d   = STOP;
                    tx_data_d = 1'b1;
                end
                default: begin
                    // End of STOP: frame complete; a rise landing here is not taken.
                    state_d    = IDLE;
                    tx_data_d  = 1'b1;
                    tx_clk_d   = 1'b0;
                    tx_frame_d = 1'b0;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                end
            endcase
        end
    end

    // State and output registers; reset also aborts any frame silently.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            en_q       <= 1'b0;
            en_d1_q    <= 1'b0;
            tx_data_q  <= 1'b1;
            tx_clk_q   <= 1'b0;
            tx_frame_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            en_q       <= en_d;
            en_d1_q    <= en_d1_d;
            tx_data_q  <= tx_data_d;
            tx_clk_q   <= tx_clk_d;
            tx_frame_q <= tx_frame_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // status[4:3] is the FSM phase itself, so the state is visible outside.
    always_comb begin
        bus.status          = '0;
        bus.status[ST_BUSY] = busy_q;
        bus.status[ST_DONE] = done_q;
        bus.status[ST_ERR]  = err_q;
        bus.status[4:3]     = state_q;
    end

    assign bus.tx_data  = tx_data_q;
    assign bus.tx_clk   = tx_clk_q;
    assign bus.tx_frame = tx_frame_q;

endmodule

// File: tb/tb_bsg_tx_serializer.sv
// tb_bsg_tx_serializer: directed bench with a frame-level reference model.
module tb_bsg_tx_serializer;

    localparam int CLK_DIV = 4;
`ifdef BSG_TX_PARITY_EN
    localparam bit          PAR_EN = 1'b1;
    localparam int          NBITS  = 18;
    localparam logic [17:0] EXP_A  = {16'hA53C, 1'b0, 1'b1};
    localparam logic [17:0] EXP_B  = {16'h0100, 1'b1, 1'b1};
`else
    localparam bit          PAR_EN = 1'b0;
    localparam int          NBITS  = 17;
    localparam logic [17:0] EXP_A  = {1'b0, 16'hA53C, 1'b1};
    localparam logic [17:0] EXP_B  = {1'b0, 16'h0100, 1'b1};
`endif
    localparam int FRAME_LEN = NBITS * CLK_DIV;

    // ---------------- clock / reset / drivers ----------------
    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       en_drv = 1'b0;
    logic [7:0] d1_drv = 8'h00;
    logic [7:0] d2_drv = 8'h00;

    always #5 clk = ~clk;

    bsg_tx_serializer_if bus();
    assign bus.tx_enable = en_drv;
    assign bus.data1     = d1_drv;
    assign bus.data2     = d2_drv;

    bsg_tx_serializer #(.CLK_DIV(CLK_DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks frame progress as "cycles since start" plus the sampled enable history.
    logic        m_active = 1'b0;
    logic        m_done   = 1'b0;
    logic        m_err    = 1'b0;
    logic        m_en1    = 1'b0;
    logic        m_en2    = 1'b0;
    int          m_t      = 0;
    logic [15:0] m_word   = 16'h0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_done   = 1'b0;
            m_err    = 1'b0;
            m_en1    = 1'b0;
            m_en2    = 1'b0;
        end else begin
            if (m_active) begin
                if (!m_en1) begin
                    m_active = 1'b0;
                    m_err    = 1'b1;
                end else if (m_t + 1 == FRAME_LEN) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end else begin
                    m_t = m_t + 1;
                end
            end else if (m_en1 && !m_en2) begin
                m_active = 1'b1;
                m_t      = 0;
                m_word   = {d1_drv, d2_drv};
                m_done   = 1'b0;
                m_err    = 1'b0;
            end
            m_en2 = m_en1;
            m_en1 = en_drv;
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        int         bit_i;
        logic [1:0] ph;
        logic       e_data, e_clk, e_frame;
        if (m_active) begin
            bit_i   = m_t / CLK_DIV;
            e_frame = 1'b1;
            e_clk   = (m_t % CLK_DIV) == 0;
            if (bit_i < 16) begin
                e_data = m_word[15 - bit_i];
                ph     = 2'd1;
            end else if (PAR_EN && bit_i == 16) begin
                e_data = ^m_word;
                ph     = 2'd2;
            end else begin
                e_data = 1'b1;
                ph     = 2'd3;
            end
        end else begin
            e_frame = 1'b0;
            e_clk   = 1'b0;
            e_data  = 1'b1;
            ph      = 2'd0;
        end
        check("model_status", 32'(bus.status), 32'({ph, m_err, m_done, m_active}));
        check("model_tx_data", 32'(bus.tx_data), 32'(e_data));
        check("model_tx_clk", 32'(bus.tx_clk), 32'(e_clk));
        check("model_tx_frame", 32'(bus.tx_frame), 32'(e_frame));
    end

    // ---------------- driver tasks ----------------
    task automatic wait_frame(output bit ok);
        int w;
        w = 0;
        while (!bus.tx_frame && w < 20) begin
            @(negedge clk);
            w++;
        end
        ok = bus.tx_frame;
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_start_timeout: tx_frame got 0 expected 1 at %0t", $time);
        end
    endtask

    // Raise enable, then measure the frame: length, strobed bits, first status.
    task automatic run_frame(input bit chg5, output int len, output logic [17:0] bits,
                             output logic [4:0] st0);
        bit ok;
        len  = 0;
        bits = '0;
        st0  = '0;
        en_drv = 1'b1;
        wait_frame(ok);
        if (ok) begin
            st0 = bus.status;
            while (bus.tx_frame && len < 400) begin
                if (bus.tx_clk) bits = {bits[16:0], bus.tx_data};
                len++;
                if (chg5 && len == 5) d1_drv = 8'hFF;
                @(negedge clk);
            end
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int          len;
        logic [17:0] bits;
        logic [4:0]  st0;
        int          starts;
        logic        prev_frame;
        bit          ok;

        repeat (3) @(negedge clk);
        check("reset_status", 32'(bus.status), 32'h0);
        check("reset_tx_data", 32'(bus.tx_data), 32'h1);
        check("reset_tx_frame", 32'(bus.tx_frame), 32'h0);
        check("reset_tx_clk", 32'(bus.tx_clk), 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Frame A5/3C, data1 disturbed mid-frame, enable then held high.
        d1_drv = 8'hA5;
        d2_drv = 8'h3C;
        run_frame(1'b1, len, bits, st0);
        check("a_first_status", 32'(st0), 32'h09);
        check("a_frame_len", 32'(len), 32'(FRAME_LEN));
        check("a_bits", 32'(bits), 32'(EXP_A));
        starts     = 0;
        prev_frame = 1'b0;
        repeat (200 - FRAME_LEN) begin
            if (bus.tx_frame && !prev_frame) starts++;
            prev_frame = bus.tx_frame;
            @(negedge clk);
        end
        check("held_no_restart", 32'(starts), 32'h0);
        check("a_done_status", 32'(bus.status), 32'h02);
        d1_drv = 8'hA5;
        en_drv = 1'b0;
        repeat (3) @(negedge clk);

        // Abort at frame cycle 20.
        en_drv = 1'b1;
        wait_frame(ok);
        repeat (20) @(negedge clk);
        en_drv = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_status", 32'(bus.status), 32'h04);
        check("abort_tx_frame", 32'(bus.tx_frame), 32'h0);
        check("abort_tx_data", 32'(bus.tx_data), 32'h1);
        repeat (2) @(negedge clk);

        // Fresh frame after abort clears ERR.
        run_frame(1'b0, len, bits, st0);
        check("b_first_status", 32'(st0), 32'h09);
        check("b_bits", 32'(bits), 32'(EXP_A));
        en_drv = 1'b0;
        repeat (3) @(negedge clk);

        // Reset at frame cycle 30.
        d1_drv = 8'h01;
        d2_drv = 8'h00;
        en_drv = 1'b1;
        wait_frame(ok);
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_status", 32'(bus.status), 32'h0);
        check("midrst_tx_data", 32'(bus.tx_data), 32'h1);
        check("midrst_tx_frame", 32'(bus.tx_frame), 32'h0);
        check("midrst_tx_clk", 32'(bus.tx_clk), 32'h0);
        rst_n  = 1'b1;
        en_drv = 1'b0;
        repeat (4) @(negedge clk);

        // Second pattern exercising odd parity content.
        run_frame(1'b0, len, bits, st0);
        check("c_frame_len", 32'(len), 32'(FRAME_LEN));
        check("c_bits", 32'(bits), 32'(EXP_B));
        check("c_done_status", 32'(bus.status), 32'h02);
        en_drv = 1'b0;
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
